// File: rtl/picture_xfer_pkg.sv
// picture_xfer_pkg: shared FSM states and default image geometry for the picture transfer bridge
package picture_xfer_pkg;
    typedef enum logic [2:0] {S_RX, S_WR, S_START, S_WAIT, S_RD, S_RDW, S_TX, S_TXG} state_e;
    localparam int IMG_W          = 352;
    localparam int IMG_H          = 288;
    localparam int BYTES_PER_WORD = 4;
    localparam int IMG_WORDS      = IMG_W * IMG_H / BYTES_PER_WORD;
endpackage

// File: rtl/picture_xfer_ctrl.sv
// picture_xfer_ctrl: packs UART bytes into memory words, hands off to the accelerator, streams the result back
module picture_xfer_ctrl
    import picture_xfer_pkg::*;
#(
    parameter int P_IMG_WORDS   = IMG_WORDS,
    parameter int P_RESULT_BASE = IMG_WORDS,
    parameter int P_ADDR_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_stb,
    output logic [7:0]          tx_data,
    output logic                tx_stb,
    input  logic                tx_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [P_ADDR_W-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                acc_start,
    input  logic                acc_done,
    output logic                busy,
    output logic                rx_drop
);
    localparam logic [P_ADDR_W-1:0] LAST     = P_ADDR_W'(P_IMG_WORDS - 1);
    localparam logic [P_ADDR_W-1:0] RES_BASE = P_ADDR_W'(P_RESULT_BASE);
    if (P_RESULT_BASE + P_IMG_WORDS > 2 ** P_ADDR_W) begin : g_geom_check
        $fatal(1, "result region does not fit in the address space");
    end
    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [P_ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]         word_q, word_d;
    logic                drop_q, drop_d;
    logic                rx_ok, last_word;
    assign rx_ok     = state_q == S_RX || state_q == S_WR;
    assign last_word = cnt_q == LAST;
    // word_q is the RX packing word while loading and the TX shift word while reading back
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        drop_d  = drop_q | (rx_stb & ~rx_ok);
        if (rx_stb && rx_ok) begin
            word_d[{idx_q, 3'b000} +: 8] = rx_data;
            idx_d = idx_q + 2'd1;
        end
        case (state_q)
            S_RX:    if (rx_stb && idx_q == 2'd3) state_d = S_WR;
            S_WR: begin
                cnt_d   = last_word ? '0 : cnt_q + 1'b1;
                state_d = last_word ? S_START : S_RX;
            end
            S_START: state_d = S_WAIT;
            S_WAIT:  if (acc_done) state_d = S_RD;
            S_RD:    state_d = S_RDW;
            S_RDW: begin
                word_d  = mem_rdata;
                idx_d   = '0;
                state_d = S_TX;
            end
            S_TX:    if (tx_ack) state_d = S_TXG;
            S_TXG: begin
                idx_d = idx_q + 2'd1;
                if (idx_q != 2'd3) state_d = S_TX;
                else begin
                    cnt_d   = last_word ? '0 : cnt_q + 1'b1;
                    state_d = last_word ? S_RX : S_RD;
                end
            end
            default: state_d = S_RX;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RX;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            drop_q  <= drop_d;
        end
    end
    assign mem_en    = state_q == S_WR || state_q == S_RD;
    assign mem_we    = state_q == S_WR;
    assign mem_addr  = state_q == S_WR ? cnt_q : state_q == S_RD ? RES_BASE + cnt_q : '0;
    assign mem_wdata = mem_we ? word_q : '0;
    assign tx_stb    = state_q == S_TX;
    assign tx_data   = tx_stb ? word_q[{idx_q, 3'b000} +: 8] : '0;
    assign acc_start = state_q == S_START;
    assign busy      = state_q != S_RX;
    assign rx_drop   = drop_q;
endmodule

// File: tb/tb_picture_xfer_ctrl.sv
// tb_picture_xfer_ctrl: randomized scoreboard bench with a memory and accelerator model
module tb_picture_xfer_ctrl;
    localparam int K_VAL = 0, K_BUSY = 1, K_TXSTB = 2, K_DROP = 3, K_OUTS = 4, K_STARTS = 5, K_ENWAIT = 6;
    typedef struct {int kind; logic [31:0] act; logic [31:0] exp; string name;} dchk_t;
    typedef struct {logic [3:0] addr; logic [31:0] data;} wr_t;

    logic        clk = 1'b0;
    logic        rst, rx_stb, tx_ack, acc_done, tx_stb, mem_en, mem_we, acc_start, busy, rx_drop;
    logic [7:0]  rx_data, tx_data;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    picture_xfer_ctrl #(.P_IMG_WORDS(2), .P_RESULT_BASE(4), .P_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb), .tx_data(tx_data),
        .tx_stb(tx_stb), .tx_ack(tx_ack), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .acc_start(acc_start), .acc_done(acc_done), .busy(busy), .rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic [31:0] res [2];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ?
                     ((mem_addr == 4'd4 || mem_addr == 4'd5) ? res[mem_addr[0]] : mem[mem_addr]) : 32'hDEAD_BEEF;
    end

    dchk_t      dq[$];
    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    int         n_pass = 0, n_total = 0, starts = 0, en_wait = 0;
    bit         in_wait = 0;
    logic       prev_stb = 1'b0;
    logic [7:0] cur_byte = '0;
    dchk_t      d;
    wr_t        w;

    task automatic q(input int kind, input logic [31:0] act, input logic [31:0] exp, input string name);
        dchk_t c;
        c.kind = kind; c.act = act; c.exp = exp; c.name = name;
        dq.push_back(c);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] pick(input dchk_t c);
        case (c.kind)
            K_BUSY:   return 32'(busy);
            K_TXSTB:  return 32'(tx_stb);
            K_DROP:   return 32'(rx_drop);
            K_OUTS:   return 32'(|{tx_data, tx_stb, mem_en, mem_we, mem_addr, mem_wdata, acc_start, busy, rx_drop});
            K_STARTS: return starts;
            K_ENWAIT: return en_wait;
            default:  return c.act;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_start) starts = starts + 1;
            if (in_wait && mem_en) en_wait = en_wait + 1;
            if (mem_en && mem_we) begin
                if (exp_wr.size() == 0) cmp("wr_unexpected", 32'(mem_addr), 32'hFFFF);
                else begin
                    w = exp_wr.pop_front();
                    cmp("wr_addr", 32'(mem_addr), 32'(w.addr));
                    cmp("wr_data", mem_wdata, w.data);
                end
            end
            if (mem_en && !mem_we) begin
                if (exp_rd.size() == 0) cmp("rd_unexpected", 32'(mem_addr), 32'hFFFF);
                else cmp("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
            if (tx_stb && !prev_stb) begin
                if (exp_tx.size() == 0) cmp("tx_unexpected", 32'(tx_data), 32'hFFFF);
                else begin
                    cur_byte = exp_tx.pop_front();
                    cmp("tx_byte", 32'(tx_data), 32'(cur_byte));
                end
            end
            if (tx_stb && tx_ack) cmp("tx_hold", 32'(tx_data), 32'(cur_byte));
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            cmp(d.name, pick(d), d.exp);
        end
        prev_stb <= tx_stb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_stb  = 1'b1;
        tick();
        rx_stb  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_stb();
        int n = 0;
        while (!tx_stb && n < 20) begin
            tick();
            n++;
        end
        if (!tx_stb) q(K_VAL, 0, 1, "tx_timeout");
    endtask

    int n_img = 0;

    task automatic run_image(input logic [7:0] b[8], input int gap[8], input logic [31:0] r0, input logic [31:0] r1,
                             input int first_d, input bit drop_wait, input int abort_k);
        logic [31:0] rw[2];
        int n;
        wr_t e;
        for (int k = 0; k < 2; k++) begin
            e.addr = 4'(k);
            e.data = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            exp_wr.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], (i == 3 || i == 7) ? 0 : gap[i]);
            if (i == 4) q(K_BUSY, 0, 0, "rx_after_wr_busy");
        end
        n_img++;
        tick();
        tick();
        in_wait = 1;
        q(K_BUSY, 0, 1, "wait_busy");
        repeat ($urandom_range(3, 10)) tick();
        if (drop_wait) begin
            send_byte(8'h5A, 0);
            q(K_DROP, 0, 1, "drop_in_wait");
        end
        q(K_STARTS, 0, n_img, "acc_start_count");
        rw[0] = r0;
        rw[1] = r1;
        res[0] = r0;
        res[1] = r1;
        for (int k = 0; k < 2; k++) begin
            exp_rd.push_back(4'(4 + k));
            for (int j = 0; j < 4; j++) exp_tx.push_back(8'(rw[k] >> (8 * j)));
        end
        acc_done = 1'b1;
        in_wait  = 0;
        tick();
        acc_done = 1'b0;
        n = 1;
        while (!tx_stb && n < 10) begin
            tick();
            n++;
        end
        q(K_VAL, n, 3, "done_to_txstb_latency");
        q(K_ENWAIT, 0, 0, "mem_en_in_wait");
        for (int k = 0; k < 8; k++) begin
            wait_stb();
            if (k == abort_k) begin
                send_byte(8'hC3, 0);
                q(K_DROP, 0, 1, "drop_in_tx");
                rst = 1'b1;
                tick();
                exp_tx.delete();
                exp_rd.delete();
                q(K_TXSTB, 0, 0, "rst_tx_stb");
                q(K_DROP, 0, 0, "rst_drop");
                q(K_BUSY, 0, 0, "rst_busy");
                rst = 1'b0;
                tick();
                return;
            end
            repeat (k == 0 ? first_d : $urandom_range(0, 4)) tick();
            q(K_TXSTB, 0, 1, "tx_stb_held");
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
        end
        tick();
        q(K_BUSY, 0, 0, "end_in_rx");
    endtask

    logic [7:0] bytes[8];
    int         gaps[8];

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_stb = 1'b0; rx_data = '0; tx_ack = 1'b0; acc_done = 1'b0;
        res[0] = '0; res[1] = '0;
        repeat (3) tick();
        rst = 1'b0;
        q(K_OUTS, 0, 0, "reset_outputs");
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        q(K_BUSY, 0, 0, "ack_ignored_busy");
        q(K_TXSTB, 0, 0, "ack_ignored_tx_stb");
        q(K_OUTS, 0, 0, "ack_ignored_outputs");
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) bytes[i] = 8'($urandom);
            gaps[i] = 1;
        end
        run_image(bytes, gaps, 32'hA1B2C3D4, 32'h01020304, 100, 1'b1, -1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                bytes[i] = 8'($urandom);
                gaps[i]  = $urandom_range(0, 3);
            end
            run_image(bytes, gaps, $urandom, $urandom, $urandom_range(0, 5), 1'b0, r == 1 ? 5 : -1);
        end
        repeat (3) tick();
        cmp("scoreboard_drained", 32'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
